// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slow-memory port between the I-cache and the D-cache.
// The registered grant selects which cache's request reaches memory and which receives the response.
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter bit FIRST_D = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, SERVE, RELEASE} state_t;

  state_t     state_q;
  logic [1:0] grant_q;
  logic       last_d_q;  // 1: the D-cache was the most recently served owner

  logic req_i, req_d, own_i, own_d, own_req;

  assign req_i   = i_mem_read | i_mem_write;
  assign req_d   = d_mem_read | d_mem_write;
  assign own_i   = (grant_q == 2'b01);
  assign own_d   = (grant_q == 2'b10);
  assign own_req = (own_i & req_i) | (own_d & req_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      last_d_q <= ~FIRST_D;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i && (!req_d || last_d_q)) begin
            state_q <= SERVE;
            grant_q <= 2'b01;
          end else if (req_d) begin
            state_q <= SERVE;
            grant_q <= 2'b10;
          end
        end
        SERVE: begin
          // Completion or owner abort both release the port and advance the pointer.
          if (mem_ready || !own_req) begin
            state_q  <= RELEASE;
            grant_q  <= 2'b00;
            last_d_q <= own_d;
          end
        end
        RELEASE: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  // grant_q is non-zero only in SERVE, so everything below is zero in IDLE/RELEASE and in reset.
  assign grant       = grant_q;
  assign mem_read    = (own_i & i_mem_read)  | (own_d & d_mem_read);
  assign mem_write   = (own_i & i_mem_write) | (own_d & d_mem_write);
  assign mem_addr    = own_i ? i_mem_addr  : (own_d ? d_mem_addr  : '0);
  assign mem_wdata   = own_i ? i_mem_wdata : (own_d ? d_mem_wdata : '0);
  assign i_mem_ready = own_i & mem_ready;
  assign d_mem_ready = own_d & mem_ready;
  assign i_mem_rdata = own_i ? mem_rdata : '0;
  assign d_mem_rdata = own_d ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed phases plus a scoreboarded contention run.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [27:0]  i_mem_addr, d_mem_addr, mem_addr;
  logic [127:0] i_mem_wdata, d_mem_wdata, i_mem_rdata, d_mem_rdata;
  logic         i_mem_ready, d_mem_ready;
  logic         mem_read, mem_write, mem_ready;
  logic [127:0] mem_wdata, mem_rdata;
  logic [1:0]   grant;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0]   owner;
    logic [27:0]  addr;
    logic [127:0] rdata;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_model(input logic [27:0] a);
    return {4{4'hC, a}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_mem_read = 0; i_mem_write = 0; i_mem_addr = '0; i_mem_wdata = '0;
    d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic reset_dut();
    step();
    rst_n = 0;
    clear_inputs();
    step();
    step();
    rst_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int served;
    int wait_cnt;
    exp_t e;

    rst_n = 0;
    clear_inputs();
    mem_ready = 1;
    mem_rdata = '1;
    smp();
    chk("rst_grant", grant, 2'b00);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_ready", i_mem_ready, 0);
    chk("rst_d_ready", d_mem_ready, 0);
    chk("rst_i_rdata", i_mem_rdata, 0);
    chk("rst_d_rdata", d_mem_rdata, 0);
    step(); rst_n = 1;
    step(); smp();
    chk("idle_grant", grant, 2'b00);
    chk("idle_mem_read", mem_read, 0);
    chk("idle_ready_ignored", d_mem_ready, 0);
    step(); mem_ready = 0; mem_rdata = '0;

    // Single I-cache read
    i_mem_read = 1; i_mem_addr = 28'h0000010;
    smp();
    chk("i1_idle_grant", grant, 2'b00);
    step(); smp();
    chk("i1_mem_read", mem_read, 1);
    chk("i1_mem_addr", mem_addr, 28'h0000010);
    chk("i1_grant", grant, 2'b01);
    step(); mem_ready = 1; mem_rdata = {16{8'hA5}};
    smp();
    chk("i1_i_ready", i_mem_ready, 1);
    chk("i1_i_rdata", i_mem_rdata, {16{8'hA5}});
    chk("i1_d_ready", d_mem_ready, 0);
    chk("i1_d_rdata", d_mem_rdata, 0);
    step(); mem_ready = 0;
    smp();
    chk("i1_release_grant", grant, 2'b00);
    chk("i1_release_read", mem_read, 0);
    step(); i_mem_read = 0;
    smp();
    chk("i1_no_regrant", grant, 2'b00);

    // Tie after reset: D first, I reaches memory 3 cycles after D's ready
    reset_dut();
    i_mem_read = 1; i_mem_addr = 28'h0000AAA;
    d_mem_read = 1; d_mem_addr = 28'h0000DDD;
    step(); smp();
    chk("tie_grant_d", grant, 2'b10);
    chk("tie_addr_d", mem_addr, 28'h0000DDD);
    step(); mem_ready = 1; mem_rdata = 128'h1234;
    smp();
    chk("tie_d_ready", d_mem_ready, 1);
    chk("tie_i_ready", i_mem_ready, 0);
    step(); mem_ready = 0; d_mem_read = 0;
    smp(); chk("tie_k1_grant", grant, 2'b00);
    step(); smp(); chk("tie_k2_grant", grant, 2'b00);
    step(); smp();
    chk("tie_k3_grant_i", grant, 2'b01);
    chk("tie_k3_addr_i", mem_addr, 28'h0000AAA);

    // Continuous contention, scoreboarded
    reset_dut();
    i_mem_read = 1; i_mem_addr = 28'h0000111;
    d_mem_read = 1; d_mem_addr = 28'h0000222;
    for (int k = 0; k < 6; k++) begin
      e.owner = (k % 2 == 0) ? 2'b10 : 2'b01;
      e.addr  = (k % 2 == 0) ? 28'h0000222 : 28'h0000111;
      e.rdata = mem_model(e.addr);
      sb.push_back(e);
    end
    served = 0;
    wait_cnt = 0;
    for (int c = 0; c < 400 && served < 6; c++) begin
      step();
      mem_ready = 0;
      if (grant != 2'b00 && (mem_read || mem_write)) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          mem_ready = 1;
          mem_rdata = mem_model(mem_addr);
          wait_cnt = 0;
        end
      end
      smp();
      if (i_mem_ready || d_mem_ready) begin
        served++;
        if (sb.size() == 0) begin
          chk("cont_sb_extra", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("cont_owner", {d_mem_ready, i_mem_ready}, e.owner);
          chk("cont_grant", grant, e.owner);
          chk("cont_addr", mem_addr, e.addr);
          chk("cont_rdata", d_mem_ready ? d_mem_rdata : i_mem_rdata, e.rdata);
        end
      end
    end
    chk("cont_served", served, 6);
    chk("cont_sb_empty", sb.size(), 0);

    // D write-back + allocate with I arriving mid-transaction
    reset_dut();
    d_mem_write = 1; d_mem_read = 1; d_mem_addr = 28'h0000123; d_mem_wdata = 128'h1;
    step(); smp();
    chk("wb_grant", grant, 2'b10);
    chk("wb_mem_write", mem_write, 1);
    chk("wb_mem_read", mem_read, 1);
    chk("wb_mem_wdata", mem_wdata, 128'h1);
    step(); i_mem_read = 1; i_mem_addr = 28'h0000777;
    smp();
    chk("wb_addr_held", mem_addr, 28'h0000123);
    chk("wb_grant_held", grant, 2'b10);
    step(); mem_ready = 1; mem_rdata = 128'hBEEF;
    smp();
    chk("wb_d_ready", d_mem_ready, 1);
    chk("wb_d_rdata", d_mem_rdata, 128'hBEEF);
    chk("wb_i_ready", i_mem_ready, 0);
    chk("wb_i_rdata", i_mem_rdata, 0);
    step(); mem_ready = 0; d_mem_read = 0; d_mem_write = 0;
    smp(); chk("wb_release", grant, 2'b00);
    step(); smp(); chk("wb_idle", grant, 2'b00);
    step(); smp();
    chk("wb_i_grant", grant, 2'b01);
    chk("wb_i_addr", mem_addr, 28'h0000777);

    // Abort: owner drops request before mem_ready
    step(); i_mem_read = 0;
    smp(); chk("ab_read_drop", mem_read, 0);
    step(); smp(); chk("ab_release", grant, 2'b00);
    step(); smp(); chk("ab_idle", grant, 2'b00);

    // Asynchronous reset mid-SERVE
    step(); i_mem_read = 1;
    step(); smp();
    chk("mr_serve_read", mem_read, 1);
    #2 rst_n = 0;
    #1;
    chk("mr_read_clear", mem_read, 0);
    chk("mr_grant_clear", grant, 2'b00);
    step(); clear_inputs(); rst_n = 1;
    step(); smp();
    chk("mr_idle_after", grant, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one slow-memory port between the instruction cache and the data cache, so the chip can run from a single external memory instead of separate I and D memories.
- Sits between the two cache instances' memory-side interfaces and the single external memory interface.
- Grants one cache at a time, forwards its request, and routes the memory's response back to that cache only.
- Resolves collisions with round-robin priority.

Parameters:
ADDR_W, 28, block address width (address bits [31:4])
DATA_W, 128, memory block width
FIRST_D, 1, tie-break owner after reset: 1 = D-cache wins the first tie, 0 = I-cache wins

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_mem_read  in  1  I-cache block read request
i_mem_write  in  1  I-cache block write request
i_mem_addr  in  ADDR_W  I-cache block address
i_mem_wdata  in  DATA_W  I-cache write block
i_mem_rdata  out  DATA_W  read block returned to I-cache
i_mem_ready  out  1  completion pulse to I-cache
d_mem_read  in  1  D-cache block read request
d_mem_write  in  1  D-cache block write request
d_mem_addr  in  ADDR_W  D-cache block address
d_mem_wdata  in  DATA_W  D-cache write block
d_mem_rdata  out  DATA_W  read block returned to D-cache
d_mem_ready  out  1  completion pulse to D-cache
mem_read  out  1  read request to memory
mem_write  out  1  write request to memory
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  write block to memory
mem_rdata  in  DATA_W  read block from memory
mem_ready  in  1  memory completion
grant  out  2  owner: 00 none, 01 I-cache, 10 D-cache (debug/perf)

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE, grant = 00.
  - Last-served pointer = I if FIRST_D=1, D if FIRST_D=0.
  - All outputs are 0: mem_read, mem_write, mem_addr, mem_wdata, both *_ready, both *_rdata.
- Request definitions: req_i = i_mem_read | i_mem_write; req_d = d_mem_read | d_mem_write.
- FSM states: IDLE, SERVE, RELEASE.
- IDLE:
  - grant = 00; all memory-side request outputs are 0.
  - Only req_i: next state SERVE, owner I.
  - Only req_d: next state SERVE, owner D.
  - Both: owner is the requester that is not the last-served one.
  - Neither: stay in IDLE.
- SERVE:
  - Memory outputs (read, write, addr, wdata) are combinationally muxed from the owner's inputs, selected by the registered grant.
  - The owner's read and write are forwarded unchanged, including both asserted at once.
  - The owner's *_ready = mem_ready; the owner's *_rdata = mem_rdata.
  - The non-owner's *_ready = 0 and *_rdata = 0.
  - On mem_ready=1: next state RELEASE; the last-served pointer becomes the owner.
  - Abort: if the owner drops both read and write before mem_ready, next state RELEASE; the pointer is still updated.
- RELEASE (one cycle):
  - grant = 00, memory request outputs = 0, all *_ready = 0.
  - Requests are ignored, so a cache still holding its request for a cycle after ready is not re-granted.
  - Next state IDLE.
- Latency:
  - Request seen in IDLE at cycle t → memory sees it at t+1.
  - mem_ready at cycle k → cache sees ready at cycle k (combinational).
  - Earliest re-grant after completion is cycle k+2; the second requester reaches memory at k+3.
- Starvation: with both caches requesting continuously, grants strictly alternate I, D, I, D.
- Non-owner input changes during SERVE have no effect on memory outputs.
- mem_ready outside SERVE is ignored and never forwarded.
- rst_n asserted mid-SERVE: outputs clear immediately (asynchronously) and state returns to IDLE; the memory transaction is abandoned.
- Pointer updates only on leaving SERVE.

Test Plan:
- Reset then idle: rst_n=0 → grant=00 and all outputs 0; release with no requests → stays IDLE, mem_read=0.
- Single I read: i_mem_read=1, i_mem_addr=28'h0000010 at cycle 1 → cycle 2: mem_read=1, mem_addr=28'h0000010, grant=01. Memory returns mem_ready with mem_rdata=128'hA5…A5 → i_mem_ready=1, i_mem_rdata=A5…A5, d_mem_ready=0. Next cycle grant=00.
- Tie after reset (FIRST_D=1): req_i and req_d in the same cycle → D served first. After D's mem_ready plus RELEASE, I is granted and reaches memory 3 cycles after D's ready.
- Continuous contention: both caches hold requests for 6 transactions → grant sequence alternates 10,01,10,01,10,01; no requester is served twice in a row.
- D write-back then allocate: d_mem_write=1 and d_mem_read=1 with addr 28'h0000123, wdata 128'h1 → mem_write=1, mem_read=1, mem_wdata=128'h1 forwarded. An i_mem_read arriving mid-transaction does not alter mem_addr.
- Abort and mid-op reset: in SERVE, the owner drops its request → RELEASE then IDLE. Asserting rst_n=0 during SERVE → mem_read drops to 0 in the same cycle and grant=00.
